// File: rtl/snake_pkg.sv
// Shared types and constants for the snake direction-input block.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned NUM_BTNS  = 4;

  localparam dir_t        RESET_DIR = DIR_RIGHT;
  localparam int unsigned DROP_W    = 8;

  // Winning press of a cycle: lowest-index button takes priority
  typedef struct packed {
    logic valid;
    dir_t dir;
  } press_sel_t;

  function automatic dir_t opposite_dir(input dir_t d);
    return d ^ 2'b01;
  endfunction

  function automatic dir_t btn_to_dir(input int unsigned idx);
    dir_t d;
    case (idx)
      BTN_UP:   d = DIR_UP;
      BTN_DOWN: d = DIR_DOWN;
      BTN_LEFT: d = DIR_LEFT;
      default:  d = DIR_RIGHT;
    endcase
    return d;
  endfunction

  function automatic press_sel_t select_press(input logic [NUM_BTNS-1:0] ev);
    press_sel_t s;
    s = '0;
    for (int i = int'(NUM_BTNS) - 1; i >= 0; i--) begin
      if (ev[i]) begin
        s.valid = 1'b1;
        s.dir   = btn_to_dir(32'(i));
      end
    end
    return s;
  endfunction

  // Presses beyond the winning one in the same cycle
  function automatic logic [1:0] extra_presses(input logic [NUM_BTNS-1:0] ev);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < int'(NUM_BTNS); i++) begin
      n = n + 3'(ev[i]);
    end
    return 2'(n - 3'(|ev));
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchronizer, stable-cycle counter, debounced state
// and a registered one-cycle press pulse on its 0->1 transition.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             press_q, press_d;

  // Counter runs only while the synchronized input disagrees with the state
  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    cnt_d   = '0;
    state_d = state_q;
    press_d = 1'b0;
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/snake_dir_input.sv
// Debounced 4-button direction input with a small turn queue popped on tick.
// Optional drop statistics counter enabled by defining SNAKE_DIR_STATS_EN.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned QUEUE_DEPTH     = 2
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [3:0]  buttons,
  input  logic        tick,
  output logic [1:0]  cur_dir,
  output logic        dir_changed,
  output logic [1:0]  queue_count,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);

  logic [NUM_BTNS-1:0] press_ev;
  press_sel_t          sel;

  dir_t             q_mem_q [QUEUE_DEPTH];
  dir_t             q_mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  dir_t             cur_dir_q, cur_dir_d;
  dir_t             prev_dir_q;
  logic             dir_changed_q;

  logic [PTR_W-1:0] tail_ptr;
  dir_t             ref_dir;
  logic             full, empty, pop, push, is_same, is_opp;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (clock_100Mhz),
      .rst_i  (reset),
      .btn_i  (buttons[g]),
      .press_o(press_ev[g])
    );
  end

  // Accept/reject decision against the most recent pending turn
  always_comb begin
    sel      = select_press(press_ev);
    tail_ptr = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - PTR_W'(1);
    full     = (count_q == CNT_FULL);
    empty    = (count_q == '0);
    ref_dir  = empty ? cur_dir_q : q_mem_q[tail_ptr];
    pop      = tick & ~empty;
    is_same  = (sel.dir == ref_dir);
    is_opp   = (sel.dir == opposite_dir(ref_dir));
    push     = sel.valid & ~is_same & ~is_opp & (~full | pop);
  end

  // Circular buffer update; push and pop in one cycle leave count unchanged
  always_comb begin
    q_mem_d   = q_mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    cur_dir_d = cur_dir_q;
    if (push) begin
      q_mem_d[wr_ptr_q] = sel.dir;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      cur_dir_d = q_mem_q[rd_ptr_q];
      rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      q_mem_q       <= '{default: RESET_DIR};
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      cur_dir_q     <= RESET_DIR;
      prev_dir_q    <= RESET_DIR;
      dir_changed_q <= 1'b0;
    end else begin
      q_mem_q       <= q_mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      cur_dir_q     <= cur_dir_d;
      prev_dir_q    <= cur_dir_q;
      dir_changed_q <= (cur_dir_q != prev_dir_q);
    end
  end

  assign cur_dir     = cur_dir_q;
  assign dir_changed = dir_changed_q;
  assign queue_count = 2'(count_q);

`ifdef SNAKE_DIR_STATS_EN
  logic              rej_counted;
  logic [2:0]        drop_inc;
  logic [DROP_W:0]   drop_sum;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  // Losing simultaneous presses plus an opposite or queue-full rejection
  always_comb begin
    rej_counted = sel.valid & ~is_same & (is_opp | (full & ~pop));
    drop_inc    = 3'(extra_presses(press_ev)) + 3'(rej_counted);
    drop_sum    = {1'b0, drop_cnt_q} + (DROP_W+1)'(drop_inc);
    drop_cnt_d  = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed bench for snake_dir_input with DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2.
module tb_snake_dir_input;

`ifdef SNAKE_DIR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic       tick;
    int         cycles;
    int         exp_dir;
    int         exp_cnt;
    int         exp_drop;
    int         exp_chg;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttons;
  logic       tick;
  logic [1:0] cur_dir;
  logic       dir_changed;
  logic [1:0] queue_count;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  snake_dir_input #(
    .DEBOUNCE_CYCLES(4),
    .QUEUE_DEPTH    (2)
  ) dut (
    .clock_100Mhz(clk),
    .reset       (reset),
    .buttons     (buttons),
    .tick        (tick),
    .cur_dir     (cur_dir),
    .dir_changed (dir_changed),
    .queue_count (queue_count),
    .drop_cnt    (drop_cnt)
  );

  function automatic vec_t mk(input logic r, input logic [3:0] b, input logic t, input int c,
                              input int d, input int n, input int dr, input int ch);
    vec_t v;
    v.rst = r; v.btn = b; v.tick = t; v.cycles = c;
    v.exp_dir = d; v.exp_cnt = n; v.exp_drop = dr; v.exp_chg = ch;
    return v;
  endfunction

  function automatic int exp_drop(input int raw);
    return STATS ? raw : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " cur_dir"},     int'(cur_dir),     v.exp_dir);
    check({tag, " queue_count"}, int'(queue_count), v.exp_cnt);
    check({tag, " drop_cnt"},    int'(drop_cnt),    exp_drop(v.exp_drop));
    check({tag, " dir_changed"}, int'(dir_changed), v.exp_chg);
  endtask

  // Drive one record for its cycle count, then sample 1 ns after the edge
  task automatic run_vec(input string tag, input vec_t v);
    reset   = v.rst;
    buttons = v.btn;
    tick    = v.tick;
    repeat (v.cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    tick  = 1'b0;
    check_outputs(tag, v);
  endtask

  vec_t vecs[$];

  initial begin
    int pulses;
    reset   = 1'b1;
    buttons = 4'b0000;
    tick    = 1'b0;

    //          rst  btn     tick cyc dir cnt drop chg
    vecs.push_back(mk(0, 4'b0001, 0, 3,  3, 0, 0, 0)); // short glitch on up
    vecs.push_back(mk(0, 4'b0000, 0, 10, 3, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 10, 3, 1, 0, 0)); // up queued
    vecs.push_back(mk(0, 4'b0000, 0, 10, 3, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1,  0, 0, 0, 0)); // pop up
    vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1,  3, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 4'b0100, 0, 10, 3, 0, 1, 0)); // left vs right: counted drop
    vecs.push_back(mk(0, 4'b0000, 0, 10, 3, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 10, 3, 1, 1, 0)); // up
    vecs.push_back(mk(0, 4'b0000, 0, 10, 3, 1, 1, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 10, 3, 2, 1, 0)); // left
    vecs.push_back(mk(0, 4'b0000, 0, 10, 3, 2, 1, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 10, 3, 2, 2, 0)); // down: queue full
    vecs.push_back(mk(0, 4'b0000, 0, 10, 3, 2, 2, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1,  0, 1, 2, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 1, 2, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 1,  2, 0, 2, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1,  2, 0, 2, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 10, 2, 1, 2, 0)); // refill up,left
    vecs.push_back(mk(0, 4'b0000, 0, 10, 2, 1, 2, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 10, 2, 2, 2, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 10, 2, 2, 2, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 6,  2, 2, 2, 0)); // down event pending
    vecs.push_back(mk(0, 4'b0010, 1, 1,  0, 2, 2, 0)); // push+pop while full
    vecs.push_back(mk(0, 4'b0010, 0, 1,  0, 2, 2, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 10, 0, 2, 2, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1,  3, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0011, 0, 10, 3, 1, 1, 0)); // up+down same cycle
    vecs.push_back(mk(0, 4'b0000, 0, 10, 3, 1, 1, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 10, 3, 2, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 10, 3, 2, 1, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1,  3, 0, 0, 0)); // reset with 2 queued
    vecs.push_back(mk(0, 4'b0000, 1, 1,  3, 0, 0, 0)); // tick on empty queue
    vecs.push_back(mk(0, 4'b0000, 0, 1,  3, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0111, 0, 10, 3, 1, 2, 0)); // three at once
    vecs.push_back(mk(0, 4'b0000, 0, 10, 3, 1, 2, 0));
    vecs.push_back(mk(1, 4'b0000, 1, 1,  3, 0, 0, 0)); // tick during reset
    vecs.push_back(mk(0, 4'b0000, 0, 1,  3, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs("reset", mk(0, 4'b0000, 0, 0, 3, 0, 0, 0));

    foreach (vecs[i]) run_vec($sformatf("row%0d", i), vecs[i]);

    // Button held through reset: one press, queued exactly 2+4+1 edges later
    run_vec("hold_pre",   mk(0, 4'b0001, 0, 4, 3, 0, 0, 0));
    run_vec("hold_rst",   mk(1, 4'b0001, 0, 1, 3, 0, 0, 0));
    run_vec("hold_early", mk(0, 4'b0001, 0, 6, 3, 0, 0, 0));
    run_vec("hold_edge",  mk(0, 4'b0001, 0, 1, 3, 1, 0, 0));
    run_vec("hold_rel",   mk(0, 4'b0000, 0, 10, 3, 1, 0, 0));

    // Exactly one dir_changed pulse per pop
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick   = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (dir_changed) pulses++;
    end
    check("pulse_count", pulses, 1);
    check("pulse_dir",   int'(cur_dir), 0);
    check("pulse_cnt",   int'(queue_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/snake_dir_input.md
SNAKE_DIR_INPUT -- requirements
Module: snake_dir_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, gives the stable-input cycles needed before a button state is accepted (10 ms at 100 MHz).
REQ-002 Parameter QUEUE_DEPTH, default 2, gives the number of pending turns held.
REQ-003 clock_100Mhz  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 buttons  input  4  raw asynchronous buttons: [0] up, [1] down, [2] left, [3] right.
REQ-006 tick  input  1  one-cycle game-step strobe from the snake position logic.
REQ-007 cur_dir  output  2  committed direction: 00 up, 01 down, 10 left, 11 right.
REQ-008 dir_changed  output  1  one-cycle pulse in the cycle after cur_dir takes a new value.
REQ-009 queue_count  output  2  number of pending turns (0..QUEUE_DEPTH).
REQ-010 drop_cnt  output  8  count of rejected presses (see Configuration).

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before debouncing.
REQ-012 Debounced state SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears that button's counter.
REQ-013 A press event SHALL be a 0->1 transition of a debounced state; releases generate nothing.
REQ-014 If several press events occur in the same cycle, only the lowest-index button SHALL be taken; the others count as dropped.
REQ-015 Reference direction = queue tail if queue non-empty at start of cycle, else cur_dir.
REQ-016 Press equal to the reference SHALL be dropped silently (not counted).
REQ-017 Press opposite the reference (dir XOR 01) SHALL be dropped and counted.
REQ-018 Press with queue full and no pop this cycle SHALL be dropped and counted.
REQ-019 Otherwise the press SHALL be appended; queue_count reflects it the next cycle.
REQ-020 On tick with queue non-empty, the head SHALL be popped into cur_dir on the next edge, and dir_changed SHALL pulse the following cycle.
REQ-021 On tick with an empty queue, cur_dir and queue_count SHALL hold, with no pulse.
REQ-022 A simultaneous push and pop SHALL both occur, leaving count unchanged; this holds when full as well.
REQ-023 The queue SHALL be a circular buffer whose read and write pointers wrap modulo QUEUE_DEPTH.
REQ-024 Worst-case latency from a stable button edge to a queued entry SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-025 On reset: cur_dir=11 (right), dir_changed=0, queue_count=0, pointers=0, drop_cnt=0, synchronizers, debounced states and debounce counters all 0.
REQ-026 Reset mid-operation SHALL discard pending turns and partial debounces; a button held through reset SHALL produce one press DEBOUNCE_CYCLES after its sync delay.
REQ-027 tick SHALL be ignored while reset is high.

Configuration
REQ-028 Macro SNAKE_DIR_STATS_EN defined: drop_cnt SHALL increment by 1 per counted drop (REQ-014/017/018), saturate at 255, and clear only on reset.
REQ-029 SNAKE_DIR_STATS_EN undefined: drop_cnt SHALL be constant 0 and the counter logic SHALL be absent.

Structure
REQ-030 Shared package snake_pkg SHALL hold the direction typedef, constants DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT, button index constants, and the reset direction.
REQ-031 A single sub-module, button_debounce (synchronizer plus counter plus debounced state), SHALL be instantiated four times.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-032 Press up for 3 cycles, then release -> no event, queue_count stays 0.
REQ-033 Reset, press up held 10 cycles, then tick -> queue_count=1, then cur_dir=00 and one dir_changed pulse.
REQ-034 cur_dir=11, press left -> dropped, drop_cnt=1 (macro on) or 0 (macro off), queue_count=0.
REQ-035 Press up, then left, then down with no tick -> queue holds up,left; down dropped; two ticks give cur_dir 00 then 10.
REQ-036 Queue full (up,left) with a tick coincident with a down press event -> pop up, push down, queue_count=2, cur_dir=00.
REQ-037 Up and down pressed in the same debounce cycle -> up queued, down counted as dropped; assert reset with 2 queued -> next cycle cur_dir=11, queue_count=0.
